syn_sram_acc_arb: RTL and testbench

//  Arbitrates the single-port pixel SRAM between the GPU pixel gateway (rd/wr)
//  and the VGA display fetcher (rd only). Registers the granted command onto the

---
 rtl/syn_sram_acc_arb.sv | 113 +++++++++++
 tb/tb_syn_sram_acc_arb.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_sram_acc_arb.sv
// Pixel SRAM arbiter: VGA display fetch vs GPU gateway, with an anti-starvation
// streak limit, a write->read turnaround gap and a tagged read-return pipe.
module syn_sram_acc_arb #(
  parameter int P_ADDR_W         = 18,
  parameter int P_DATA_W         = 16,
  parameter int P_RD_LAT         = 2,
  parameter int P_VGA_MAX_STREAK = 8,
  parameter int P_WR2RD_GAP      = 1
) (
  input  logic                clk_ir,
  input  logic                rst_sync,
  input  logic [P_ADDR_W-1:0] gpu_addr,
  input  logic                gpu_rd_en,
  input  logic                gpu_wr_en,
  input  logic [P_DATA_W-1:0] gpu_wr_data,
  output logic                gpu_rdy,
  output logic                gpu_rd_valid,
  output logic [P_DATA_W-1:0] gpu_rd_data,
  input  logic [P_ADDR_W-1:0] vga_addr,
  input  logic                vga_rd_en,
  output logic                vga_rdy,
  output logic                vga_rd_valid,
  output logic [P_DATA_W-1:0] vga_rd_data,
  output logic [P_ADDR_W-1:0] sram_addr,
  output logic                sram_rd_en,
  output logic                sram_wr_en,
  output logic [P_DATA_W-1:0] sram_wr_data,
  input  logic [P_DATA_W-1:0] sram_rd_data
);

  localparam int SW = $clog2(P_VGA_MAX_STREAK + 1);
  localparam int TW = (P_WR2RD_GAP > 0) ? $clog2(P_WR2RD_GAP + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(P_VGA_MAX_STREAK);
  localparam logic [TW-1:0] GAP = TW'(P_WR2RD_GAP);

  logic [SW-1:0]       streak;
  logic [TW-1:0]       ta;
  logic                iss_vga;
  logic [P_RD_LAT-1:0] tag_v;
  logic [P_RD_LAT-1:0] tag_vga;

  logic rd_blk;
  logic vga_el;
  logic gpu_el;
  logic gpu_req;
  logic vga_gnt;
  logic gpu_gnt;
  logic wr_gnt;

  assign rd_blk  = (ta != '0);
  assign vga_el  = vga_rd_en & ~rd_blk;
  assign gpu_el  = gpu_wr_en | (gpu_rd_en & ~rd_blk);
  assign gpu_req = gpu_wr_en | gpu_rd_en;

  // VGA wins ties until the GPU has waited out a full streak
  assign vga_gnt = ~rst_sync & vga_el &
                   (~gpu_el | (streak != STREAK_MAX));
  assign gpu_gnt = ~rst_sync & gpu_el & ~vga_gnt;
  assign wr_gnt  = gpu_gnt & gpu_wr_en;

  assign vga_rdy = vga_gnt;
  assign gpu_rdy = gpu_gnt;

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      sram_addr    <= '0;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_wr_data <= '0;
      iss_vga      <= 1'b0;
      streak       <= '0;
      ta           <= '0;
      tag_v        <= '0;
      tag_vga      <= '0;
    end else begin
      sram_rd_en <= vga_gnt | (gpu_gnt & ~gpu_wr_en);
      sram_wr_en <= wr_gnt;
      iss_vga    <= vga_gnt;
      if (vga_gnt)
        sram_addr <= vga_addr;
      else if (gpu_gnt)
        sram_addr <= gpu_addr;
      if (wr_gnt)
        sram_wr_data <= gpu_wr_data;

      if (wr_gnt)
        ta <= GAP;
      else if (ta != '0)
        ta <= ta - TW'(1);

      if (gpu_gnt | ~gpu_req)
        streak <= '0;
      else if (vga_gnt && streak != STREAK_MAX)
        streak <= streak + SW'(1);

      // tag slot k lines up with sram_rd_data k+1 cycles after issue
      tag_v[0]   <= sram_rd_en;
      tag_vga[0] <= iss_vga;
      for (int i = 1; i < P_RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_vga[i] <= tag_vga[i-1];
      end
    end
  end

  assign vga_rd_valid = ~rst_sync & tag_v[P_RD_LAT-1] &
                        tag_vga[P_RD_LAT-1];
  assign gpu_rd_valid = ~rst_sync & tag_v[P_RD_LAT-1] &
                        ~tag_vga[P_RD_LAT-1];
  assign vga_rd_data  = rst_sync ? '0 : sram_rd_data;
  assign gpu_rd_data  = rst_sync ? '0 : sram_rd_data;

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Bench for syn_sram_acc_arb: directed stimulus feeding an expected-return
// queue, drained by an independent monitor on rd_valid pulses.
module tb_syn_sram_acc_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] gpu_addr;
  logic        gpu_rd_en;
  logic        gpu_wr_en;
  logic [15:0] gpu_wr_data;
  logic        gpu_rdy;
  logic        gpu_rd_valid;
  logic [15:0] gpu_rd_data;
  logic [17:0] vga_addr;
  logic        vga_rd_en;
  logic        vga_rdy;
  logic        vga_rd_valid;
  logic [15:0] vga_rd_data;
  logic [17:0] sram_addr;
  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [15:0] sram_wr_data;
  logic [15:0] sram_rd_data;

  always #5 clk = ~clk;

  syn_sram_acc_arb dut (
    .clk_ir       (clk),
    .rst_sync     (rst),
    .gpu_addr     (gpu_addr),
    .gpu_rd_en    (gpu_rd_en),
    .gpu_wr_en    (gpu_wr_en),
    .gpu_wr_data  (gpu_wr_data),
    .gpu_rdy      (gpu_rdy),
    .gpu_rd_valid (gpu_rd_valid),
    .gpu_rd_data  (gpu_rd_data),
    .vga_addr     (vga_addr),
    .vga_rd_en    (vga_rd_en),
    .vga_rdy      (vga_rdy),
    .vga_rd_valid (vga_rd_valid),
    .vga_rd_data  (vga_rd_data),
    .sram_addr    (sram_addr),
    .sram_rd_en   (sram_rd_en),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_data (sram_wr_data),
    .sram_rd_data (sram_rd_data)
  );

  typedef struct packed {
    logic        vga;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Background pixel content of unwritten addresses
  function automatic logic [15:0] pix(input logic [17:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: 2-cycle read latency, remembers the most recent write
  logic        wv = 1'b0;
  logic [17:0] wa = '0;
  logic [15:0] wd = '0;
  logic [15:0] d1 = '0;

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    if (wv && a == wa) return wd;
    if (a == 18'h12C0) return 16'hBEEF;
    return pix(a);
  endfunction

  initial sram_rd_data = '0;

  always @(posedge clk) begin
    if (sram_wr_en) begin
      wv <= 1'b1;
      wa <= sram_addr;
      wd <= sram_wr_data;
    end
    d1 <= sram_rd_en ? mem_rd(sram_addr) : 16'h0;
    sram_rd_data <= d1;
  end

  // Monitor
  int   n_rd = 0;
  int   n_wr = 0;
  int   n_gv = 0;
  int   n_adj = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (gpu_rd_valid || vga_rd_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rd_valid: got gpu=%0b vga=%0b expected none",
                 gpu_rd_valid, vga_rd_valid);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_tag_vga", {31'd0, vga_rd_valid}, {31'd0, e.vga});
        chk("rd_both_valid", {31'd0, gpu_rd_valid & vga_rd_valid}, 32'd0);
        chk("rd_data", {16'd0, vga_rd_valid ? vga_rd_data : gpu_rd_data},
            {16'd0, e.data});
      end
    end
    if (sram_rd_en) n_rd <= n_rd + 1;
    if (sram_wr_en) n_wr <= n_wr + 1;
    if (gpu_rd_valid) n_gv <= n_gv + 1;
    if (sram_rd_en && prev_wr) n_adj <= n_adj + 1;
    prev_wr <= sram_wr_en;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      nxt();
      k++;
    end
    chk("drain_queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    logic [17:0] va;
    logic [17:0] ga;
    int          rd0;
    int          wr0;
    int          gv0;

    rst         = 1'b1;
    gpu_addr    = '0;
    gpu_rd_en   = 1'b0;
    gpu_wr_en   = 1'b0;
    gpu_wr_data = '0;
    vga_addr    = '0;
    vga_rd_en   = 1'b0;

    // Reset state
    idle(2);
    gpu_rd_en = 1'b1;
    vga_rd_en = 1'b1;
    @(negedge clk);
    chk("rst_gpu_rdy", {31'd0, gpu_rdy}, 32'd0);
    chk("rst_vga_rdy", {31'd0, vga_rdy}, 32'd0);
    chk("rst_sram_rd_en", {31'd0, sram_rd_en}, 32'd0);
    chk("rst_sram_wr_en", {31'd0, sram_wr_en}, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_rd_valid", {30'd0, gpu_rd_valid, vga_rd_valid}, 32'd0);
    nxt();
    gpu_rd_en = 1'b0;
    vga_rd_en = 1'b0;
    rst = 1'b0;
    idle(2);

    // 1: lone GPU read
    gpu_rd_en = 1'b1;
    gpu_addr  = 18'h12C0;
    @(negedge clk);
    chk("t1_gpu_rdy", {31'd0, gpu_rdy}, 32'd1);
    if (gpu_rdy) q.push_back('{vga: 1'b0, data: 16'hBEEF});
    nxt();
    gpu_rd_en = 1'b0;
    @(negedge clk);
    chk("t1_sram_rd_en", {31'd0, sram_rd_en}, 32'd1);
    chk("t1_sram_addr", {14'd0, sram_addr}, 32'h12C0);
    idle(2);
    @(negedge clk);
    chk("t1_gpu_rd_valid", {31'd0, gpu_rd_valid}, 32'd1);
    chk("t1_vga_rd_valid", {31'd0, vga_rd_valid}, 32'd0);
    chk("t1_gpu_rd_data", {16'd0, gpu_rd_data}, 32'hBEEF);
    nxt();
    drain();
    idle(2);

    // 2: VGA and GPU both held: 8 VGA, 1 GPU, 8 VGA
    va = 18'h100;
    ga = 18'h2000;
    vga_rd_en = 1'b1;
    gpu_rd_en = 1'b1;
    vga_addr  = va;
    gpu_addr  = ga;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      chk($sformatf("t2_vga_rdy_%0d", i), {31'd0, vga_rdy},
          {31'd0, (i != 8)});
      chk($sformatf("t2_gpu_rdy_%0d", i), {31'd0, gpu_rdy},
          {31'd0, (i == 8)});
      if (vga_rdy) q.push_back('{vga: 1'b1, data: pix(va)});
      if (gpu_rdy) q.push_back('{vga: 1'b0, data: pix(ga)});
      nxt();
      if (vga_rdy) va = va + 18'd1;
      if (gpu_rdy) ga = ga + 18'd1;
      vga_addr = va;
      gpu_addr = ga;
    end
    vga_rd_en = 1'b0;
    gpu_rd_en = 1'b0;
    drain();
    idle(2);

    // 3: GPU write, then VGA read is held off one cycle
    gpu_wr_en   = 1'b1;
    gpu_addr    = 18'h30;
    gpu_wr_data = 16'h1234;
    @(negedge clk);
    chk("t3_gpu_wr_rdy", {31'd0, gpu_rdy}, 32'd1);
    nxt();
    gpu_wr_en = 1'b0;
    vga_rd_en = 1'b1;
    vga_addr  = 18'h30;
    @(negedge clk);
    chk("t3_vga_blocked", {31'd0, vga_rdy}, 32'd0);
    nxt();
    @(negedge clk);
    chk("t3_vga_granted", {31'd0, vga_rdy}, 32'd1);
    if (vga_rdy) q.push_back('{vga: 1'b1, data: 16'h1234});
    nxt();
    vga_rd_en = 1'b0;
    drain();
    idle(2);

    // 4: rd_en and wr_en together behave as a write
    rd0 = n_rd;
    wr0 = n_wr;
    gv0 = n_gv;
    gpu_wr_en   = 1'b1;
    gpu_rd_en   = 1'b1;
    gpu_addr    = 18'd5;
    gpu_wr_data = 16'h00FF;
    @(negedge clk);
    chk("t4_gpu_rdy", {31'd0, gpu_rdy}, 32'd1);
    nxt();
    gpu_wr_en = 1'b0;
    gpu_rd_en = 1'b0;
    @(negedge clk);
    chk("t4_sram_wr_en", {31'd0, sram_wr_en}, 32'd1);
    chk("t4_sram_addr", {14'd0, sram_addr}, 32'd5);
    chk("t4_sram_wr_data", {16'd0, sram_wr_data}, 32'h00FF);
    idle(6);
    chk("t4_wr_count", n_wr - wr0, 32'd1);
    chk("t4_rd_count", n_rd - rd0, 32'd0);
    chk("t4_gpu_valid_count", n_gv - gv0, 32'd0);
    gpu_rd_en = 1'b1;
    gpu_addr  = 18'd5;
    @(negedge clk);
    chk("t4_readback_rdy", {31'd0, gpu_rdy}, 32'd1);
    if (gpu_rdy) q.push_back('{vga: 1'b0, data: 16'h00FF});
    nxt();
    gpu_rd_en = 1'b0;
    drain();
    idle(2);

    // 5: back-to-back VGA reads
    va = 18'h4000;
    vga_rd_en = 1'b1;
    vga_addr  = va;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_vga_rdy_%0d", i), {31'd0, vga_rdy}, 32'd1);
      if (i > 0) begin
        chk($sformatf("t5_sram_rd_en_%0d", i - 1), {31'd0, sram_rd_en}, 32'd1);
        chk($sformatf("t5_sram_addr_%0d", i - 1), {14'd0, sram_addr},
            {14'd0, va - 18'd1});
      end
      if (vga_rdy) q.push_back('{vga: 1'b1, data: pix(va)});
      nxt();
      va = va + 18'd1;
      vga_addr = va;
    end
    vga_rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_vga_rd_valid_%0d", i), {31'd0, vga_rd_valid}, 32'd1);
      nxt();
    end
    drain();
    idle(2);

    // 6: reset kills an in-flight VGA read
    vga_rd_en = 1'b1;
    vga_addr  = 18'h77;
    @(negedge clk);
    chk("t6_vga_rdy", {31'd0, vga_rdy}, 32'd1);
    nxt();
    vga_rd_en = 1'b0;
    @(negedge clk);
    chk("t6_sram_rd_en", {31'd0, sram_rd_en}, 32'd1);
    nxt();
    rst = 1'b1;
    vga_rd_en = 1'b1;
    @(negedge clk);
    chk("t6_rst_vga_rdy", {31'd0, vga_rdy}, 32'd0);
    nxt();
    @(negedge clk);
    chk("t6_rst_rdy", {30'd0, gpu_rdy, vga_rdy}, 32'd0);
    chk("t6_rst_strobes", {30'd0, sram_rd_en, sram_wr_en}, 32'd0);
    chk("t6_rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    chk("t6_rst_sram_wr_data", {16'd0, sram_wr_data}, 32'd0);
    chk("t6_rst_rd_valid", {30'd0, gpu_rd_valid, vga_rd_valid}, 32'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_resume_vga_rdy", {31'd0, vga_rdy}, 32'd1);
    if (vga_rdy) q.push_back('{vga: 1'b1, data: pix(18'h77)});
    nxt();
    vga_rd_en = 1'b0;
    drain();
    idle(3);

    chk("wr_rd_adjacent", n_adj, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
